// File: rtl/output_sequencer.sv
// output_sequencer: dual-channel relay drive and complementary heartbeat with supervised self-test.
// Relay readback supervision (synchroniser, self-test check, fault code 5) is built only with OUTSEQ_FB_CHECK_EN.
module output_sequencer #(
    parameter int HB_DIV       = 8,
    parameter int TEST_CYC     = 32,
    parameter int WDOG_CYC     = 64,
    parameter int MISMATCH_MAX = 3,
    parameter int FB_DLY       = 16
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    input  logic       stop,
    input  logic       clrFault,
    input  logic       cmpValid1,
    input  logic       cmpValid2,
    input  logic       cmpMatch1,
    input  logic       cmpMatch2,
    input  logic       relayFb,
    output logic       relayCtrl1,
    output logic       relayCtrl2,
    output logic       switchCtrl1,
    output logic       switchCtrl2,
    output logic [1:0] state,
    output logic [2:0] faultCode,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELFTEST = 2'd1,
        RUN      = 2'd2,
        FAULT    = 2'd3
    } seqState_e;

    localparam int HB_W = $clog2(HB_DIV);
    localparam int ST_W = $clog2(TEST_CYC + 1);
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(TEST_CYC - 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYC);
    localparam logic [3:0]      MIS_LIM = 4'(MISMATCH_MAX);

    function automatic logic [3:0] satInc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    seqState_e       curState, nextState;
    logic [2:0]      codeNext;
    logic [HB_W-1:0] hbCnt;
    logic [ST_W-1:0] stCnt;
    logic [WD_W-1:0] wd1, wd2;
    logic [3:0]      misCnt, misInc;
    logic            seen1, seen2;
    logic            good1, good2, misAny, matchAny, pass1, pass2;
    logic            wdTo1, wdTo2, runEntry, swNext;
    logic            fbClosed, fbLost;

`ifdef OUTSEQ_FB_CHECK_EN
    localparam int FB_W = $clog2(FB_DLY + 1);
    localparam logic [FB_W-1:0] FB_LAST = FB_W'(FB_DLY);

    logic            fbMeta, fbS;
    logic [FB_W-1:0] fbCnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fbMeta <= 1'b0;
            fbS    <= 1'b0;
            fbCnt  <= '0;
        end else begin
            fbMeta <= relayFb;
            fbS    <= fbMeta;
            if (curState != RUN)
                fbCnt <= '0;
            else if (fbCnt != FB_LAST)
                fbCnt <= fbCnt + 1'b1;
        end
    end

    // Contacts closed while de-energised, or still open once the pull-in window has passed
    assign fbClosed = fbS;
    assign fbLost   = (fbCnt == FB_LAST) && !fbS;
`else
    logic unusedFb;
    assign unusedFb = relayFb & (FB_DLY > 0);
    assign fbClosed = 1'b0;
    assign fbLost   = 1'b0;
`endif

    always_comb begin
        good1    = cmpValid1 & cmpMatch1;
        good2    = cmpValid2 & cmpMatch2;
        misAny   = (cmpValid1 & ~cmpMatch1) | (cmpValid2 & ~cmpMatch2);
        matchAny = good1 | good2;
        pass1    = seen1 | good1;
        pass2    = seen2 | good2;
        misInc   = satInc4(misCnt);
        // A strobe arriving while the count sits at zero still rescues the channel
        wdTo1    = (wd1 == '0) & ~cmpValid1;
        wdTo2    = (wd2 == '0) & ~cmpValid2;

        nextState = curState;
        codeNext  = faultCode;
        case (curState)
            IDLE: begin
                if (start && !stop)
                    nextState = SELFTEST;
            end
            SELFTEST: begin
                if (misAny || fbClosed) begin
                    nextState = FAULT;
                    codeNext  = 3'd1;
                end else if (stCnt == ST_LAST) begin
                    if (pass1 && pass2) begin
                        nextState = RUN;
                    end else begin
                        nextState = FAULT;
                        codeNext  = 3'd1;
                    end
                end
            end
            RUN: begin
                if (fbLost) begin
                    nextState = FAULT;
                    codeNext  = 3'd5;
                end else if (wdTo1) begin
                    nextState = FAULT;
                    codeNext  = 3'd2;
                end else if (wdTo2) begin
                    nextState = FAULT;
                    codeNext  = 3'd3;
                end else if (misAny && (misInc >= MIS_LIM)) begin
                    nextState = FAULT;
                    codeNext  = 3'd4;
                end else if (stop) begin
                    nextState = IDLE;
                end
            end
            FAULT: begin
                if (clrFault && !misAny && !fbClosed) begin
                    nextState = IDLE;
                    codeNext  = 3'd0;
                end
            end
        endcase

        runEntry = (nextState == RUN) && (curState != RUN);
        if (nextState != RUN || runEntry)
            swNext = 1'b0;
        else if (hbCnt == HB_LAST)
            swNext = ~switchCtrl1;
        else
            swNext = switchCtrl1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            curState    <= IDLE;
            faultCode   <= 3'd0;
            running     <= 1'b0;
            relayCtrl1  <= 1'b0;
            relayCtrl2  <= 1'b0;
            switchCtrl1 <= 1'b0;
            switchCtrl2 <= 1'b0;
        end else begin
            curState    <= nextState;
            faultCode   <= codeNext;
            running     <= (nextState == RUN);
            relayCtrl1  <= (nextState == RUN);
            relayCtrl2  <= 1'b0;
            switchCtrl1 <= swNext;
            switchCtrl2 <= (nextState == RUN) & ~swNext;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stCnt  <= '0;
            seen1  <= 1'b0;
            seen2  <= 1'b0;
            hbCnt  <= '0;
            wd1    <= '0;
            wd2    <= '0;
            misCnt <= '0;
        end else begin
            if (curState == SELFTEST) begin
                stCnt <= stCnt + 1'b1;
                seen1 <= pass1;
                seen2 <= pass2;
            end else begin
                stCnt <= '0;
                seen1 <= 1'b0;
                seen2 <= 1'b0;
            end

            if (nextState != RUN || runEntry || hbCnt == HB_LAST)
                hbCnt <= '0;
            else
                hbCnt <= hbCnt + 1'b1;

            if (runEntry) begin
                wd1    <= WD_LOAD;
                wd2    <= WD_LOAD;
                misCnt <= '0;
            end else if (curState == RUN) begin
                wd1 <= cmpValid1 ? WD_LOAD : ((wd1 == '0) ? wd1 : wd1 - 1'b1);
                wd2 <= cmpValid2 ? WD_LOAD : ((wd2 == '0) ? wd2 : wd2 - 1'b1);
                if (misAny)
                    misCnt <= misInc;
                else if (matchAny)
                    misCnt <= '0;
            end else begin
                wd1    <= '0;
                wd2    <= '0;
                misCnt <= '0;
            end
        end
    end

    assign state = curState;

endmodule

// File: doc/output_sequencer.md
# output_sequencer

Safety controller in the bus comparator's output path, upstream of the output block. It collects match/mismatch verdicts from the two redundant compare channels and runs a supervised start-up self-test. It generates the dual-channel relay control and the complementary toggling switch heartbeats that the output block needs to keep the output board powered. Any fault latches the outputs into the safe, de-energised state until the fault is explicitly cleared.

## Interface
Parameters:
- HB_DIV, 8: heartbeat half-period in clk cycles (≥2)
- TEST_CYC, 32: self-test duration in cycles
- WDOG_CYC, 64: per-channel verdict watchdog timeout in cycles
- MISMATCH_MAX, 3: consecutive mismatches that raise a fault (1..15)
- FB_DLY, 16: cycles allowed for relay readback to assert after RUN entry

Ports:
- clk  in  1  sole clock; all logic is on the rising edge
- rstN  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to leave IDLE
- stop  in  1  one-cycle request to return from RUN to IDLE
- clrFault  in  1  one-cycle request to leave FAULT
- cmpValid1 / cmpValid2  in  1  channel verdict strobe
- cmpMatch1 / cmpMatch2  in  1  verdict, qualified by the matching cmpValid
- relayFb  in  1  asynchronous relay contact readback (1 = closed)
- relayCtrl1 / relayCtrl2  out  1  relay drive; relay is energised only when the two differ
- switchCtrl1 / switchCtrl2  out  1  heartbeat outputs to the output block
- state  out  2  0 IDLE, 1 SELFTEST, 2 RUN, 3 FAULT
- faultCode  out  3  latched cause (see Operation)
- running  out  1  high only in RUN

## Operation
- **Registers and reset.** All outputs are registered. Reset values: state=IDLE, relayCtrl1=0, relayCtrl2=0, switchCtrl1=0, switchCtrl2=0, faultCode=0, running=0.
- **relayFb synchronisation.** relayFb passes through a 2-flop synchroniser; fbS denotes the synchronised value.
- **IDLE.** Relay off (1/0 pair not driven: both 0). Switch outputs held 0. start → SELFTEST.
- **SELFTEST.**
  - Runs exactly TEST_CYC cycles. Relay stays off; switch outputs stay 0.
  - Pass condition: each channel delivers ≥1 cmpValid with cmpMatch=1, no mismatch occurs, and fbS=0 on every cycle.
  - Any mismatch, or fbS=1, → FAULT with code 1 immediately.
  - At the end of TEST_CYC: pass → RUN; missing verdicts → FAULT with code 1.
  - start and stop are ignored in this state.
- **RUN.**
  - relayCtrl1=1, relayCtrl2=0.
  - Heartbeat: switchCtrl1 toggles every HB_DIV cycles, starting at 0. switchCtrl2 = ~switchCtrl1.
  - Per-channel watchdog is loaded with WDOG_CYC on RUN entry and on each cmpValid of that channel.
  - Mismatch counter (4 bits): increments once per cycle in which either channel strobes cmpValid with cmpMatch=0. A cycle with at least one match and no mismatch clears it. The counter saturates at 15.
  - stop → IDLE.
- **FAULT.**
  - Entered on: watchdog reaching 0 (code 2 for channel 1, code 3 for channel 2), mismatch count reaching MISMATCH_MAX (code 4), or a feedback error (code 5).
  - Feedback error: fbS=0 on any cycle once FB_DLY cycles have elapsed since RUN entry.
  - When several causes occur in the same cycle, priority is 5 > 2 > 3 > 4.
  - Relay off and both switch outputs 0, on the same edge the state enters FAULT.
  - Exit: clrFault → IDLE with faultCode cleared. If clrFault coincides with a new fault condition, the block stays in FAULT.
- **Request priority.** When requests coincide, fault detection outranks stop, and stop outranks start.
- **Reset mid-operation.** Asserting rstN asynchronously forces the reset values. The heartbeat stops and all counters are cleared.

## Timing
- A request or condition sampled at edge N appears in the state and outputs after edge N+1.
- relayFb-to-decision latency is 2 cycles of synchroniser delay plus the 1-cycle register.
- Watchdog: if a channel gives no cmpValid for WDOG_CYC consecutive RUN cycles, FAULT follows on the next edge. A cmpValid arriving in the cycle the count reaches 0 reloads it and no fault is raised.
- Heartbeat counter width is $clog2(HB_DIV). The counter wraps to 0 on each toggle and is reset to 0 on RUN entry.
- The SELFTEST cycle counter counts 0..TEST_CYC-1 and then evaluates the pass condition.

## Configuration
- OUTSEQ_FB_CHECK_EN
  - Defined: relayFb, its synchroniser, the SELFTEST feedback check and fault code 5 are implemented.
  - Undefined: relayFb is ignored, no feedback fault is ever raised, and code 5 never appears.

## Test plan
- **Clean start.** Reset, start, both channels matching every 4 cycles, fbS following the relay → state 1 for 32 cycles, then 2. relayCtrl1/2=1/0, switchCtrl1 toggles every 8 cycles, switchCtrl2 is its complement.
- **Mismatch limit.** In RUN, 3 consecutive mismatch strobes → state 3, faultCode=4, all four control outputs 0 on the next edge. Two mismatches followed by a match → no fault.
- **Watchdog.** In RUN, channel 2 silent for 64 cycles while channel 1 stays active → faultCode=3. A simultaneous channel 1 timeout → faultCode=2.
- **Feedback.** With OUTSEQ_FB_CHECK_EN defined, relayFb held 0 after RUN entry → FAULT code 5 at cycle 16 plus synchroniser latency. With the macro undefined → stays in RUN.
- **Clear collision.** clrFault in the same cycle as a new fault condition → stays in FAULT. clrFault alone → IDLE with faultCode=0.
- **Async reset.** rstN low mid-RUN, between clock edges → all outputs 0 and state=0 immediately, without waiting for a clock edge.
